// File: rtl/sdram_fb_reader.sv
`default_nettype none
// ============================================================================
//  Module   : sdram_fb_reader
//  Purpose  : Framebuffer fetch engine. Walks a linear frame of 16-bit pixel
//             words through the SDRAM controller's single-word read port,
//             one read outstanding at a time, and buffers the returned words
//             in a show-ahead FIFO that the display timing logic pops.
//  Ports    : clk, rst (async, active-high)
//             rd_addr/rd_enable -> controller request (level-held)
//             busy/rd_ready/rd_data <- controller status and return data
//             frame_start        <- restart fetch at FB_BASE
//             pix_req            <- pop FIFO head
//             pix_data/pix_valid -> show-ahead FIFO head
//             frame_done         -> every word of the frame returned
//             underflow          -> sticky, pop attempted while empty
//             underflow_cnt      -> saturating underflow event count
//  Options  : FB_READER_STATS_EN  - when defined, underflow_cnt counts
//             underflow events; otherwise it is tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module sdram_fb_reader #(
    parameter int HADDR_WIDTH = 22,
    parameter int FB_BASE     = 0,
    parameter int FRAME_WORDS = 614400,
    parameter int FIFO_AW     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [HADDR_WIDTH-1:0] rd_addr,
    output logic                   rd_enable,
    input  logic                   busy,
    input  logic                   rd_ready,
    input  logic [15:0]            rd_data,
    input  logic                   frame_start,
    input  logic                   pix_req,
    output logic [15:0]            pix_data,
    output logic                   pix_valid,
    output logic                   frame_done,
    output logic                   underflow,
    output logic [15:0]            underflow_cnt
);

    localparam int                  c_OFFW     = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam logic [c_OFFW-1:0]   c_LAST_OFF = c_OFFW'(FRAME_WORDS - 1);
    localparam logic [c_OFFW-1:0]   c_OFF_ONE  = c_OFFW'(1);
    localparam int                  c_DEPTH_N  = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]    c_DEPTH    = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0]    c_CNT_ONE  = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0]  c_PTR_ONE  = FIFO_AW'(1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_WAIT  = 2'd2;
    localparam logic [1:0] c_ST_GAP   = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               r_rd_enable;
    logic [c_OFFW-1:0]  r_offset;
    logic               r_frame_done;
    logic               r_pending;
    logic               r_discard;
    logic               r_underflow;

    logic [15:0]        r_mem [0:c_DEPTH_N-1];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;

    logic w_pend;
    logic w_apply;
    logic w_accept;
    logic w_ret;
    logic w_push;
    logic w_empty;
    logic w_pop;
    logic w_uf;

    // A frame_start arriving this cycle counts as pending immediately, so the
    // FSM never launches a read with the old address on the restart edge.
    assign w_pend   = r_pending | frame_start;
    // Restart is only applied when no read is outstanding.
    assign w_apply  = w_pend && ((r_state == c_ST_IDLE) || (r_state == c_ST_GAP));
    // Acceptance needs rd_enable to have been visible for at least one cycle.
    assign w_accept = (r_state == c_ST_ISSUE) && r_rd_enable && busy;
    assign w_ret    = (r_state == c_ST_WAIT) && rd_ready;
    // A word returning on the flush edge belongs to the abandoned frame.
    assign w_push   = w_ret && !r_discard && !frame_start;
    assign w_empty  = (r_count == '0);
    assign w_pop    = pix_req && !w_empty && !frame_start;
    assign w_uf     = pix_req && w_empty;

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                // One read in flight at most, so count < depth reserves the
                // slot its word will land in.
                if (!r_frame_done && !w_pend && (r_count < c_DEPTH)) begin
                    w_state_nxt = c_ST_ISSUE;
                end
            end
            c_ST_ISSUE: begin
                if (w_accept) begin
                    w_state_nxt = c_ST_WAIT;
                end
            end
            c_ST_WAIT: begin
                if (rd_ready) begin
                    w_state_nxt = c_ST_GAP;
                end
            end
            c_ST_GAP: begin
                // Lets the controller's busy settle before the next request.
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Request is registered: it rises the cycle after ISSUE is entered and
    // drops on the edge where busy is seen with the request already up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_enable <= 1'b0;
        end else begin
            r_rd_enable <= (r_state == c_ST_ISSUE) && !w_accept;
        end
    end

    // ------------------------------------------------------------------------
    // Address counter, restart and frame completion
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_offset     <= '0;
            r_frame_done <= 1'b1;
            r_pending    <= 1'b0;
            r_discard    <= 1'b0;
        end else if (w_apply) begin
            r_offset     <= '0;
            r_frame_done <= 1'b0;
            r_pending    <= 1'b0;
            r_discard    <= 1'b0;
        end else begin
            if (frame_start) begin
                r_pending <= 1'b1;
                if ((r_state == c_ST_ISSUE) || (r_state == c_ST_WAIT)) begin
                    r_discard <= 1'b1;
                end
            end
            if (w_ret) begin
                r_offset <= (r_offset == c_LAST_OFF) ? '0 : (r_offset + c_OFF_ONE);
                if ((r_offset == c_LAST_OFF) && !r_discard && !frame_start) begin
                    r_frame_done <= 1'b1;
                end
            end
        end
    end

    assign rd_addr    = HADDR_WIDTH'(FB_BASE) + HADDR_WIDTH'(r_offset);
    assign rd_enable  = r_rd_enable;
    assign frame_done = r_frame_done;

    // ------------------------------------------------------------------------
    // Show-ahead FIFO
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= rd_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (frame_start) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign pix_valid = !w_empty;
    // Head is forced to zero while empty so stale storage never shows.
    assign pix_data  = w_empty ? 16'h0000 : r_mem[r_rd_ptr];

    // ------------------------------------------------------------------------
    // Underflow flag and optional event counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_underflow <= 1'b0;
        end else if (frame_start) begin
            r_underflow <= 1'b0;
        end else if (w_uf) begin
            r_underflow <= 1'b1;
        end
    end

    assign underflow = r_underflow;

`ifdef FB_READER_STATS_EN
    logic [15:0] r_uf_cnt;

    // Not cleared by frame_start: counts across frames until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_uf_cnt <= 16'h0000;
        end else if (w_uf && (r_uf_cnt != 16'hFFFF)) begin
            r_uf_cnt <= r_uf_cnt + 16'h0001;
        end
    end

    assign underflow_cnt = r_uf_cnt;
`else
    assign underflow_cnt = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sdram_fb_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sdram_fb_reader
//  Purpose  : Self-checking bench for sdram_fb_reader with a 5-cycle latency
//             SDRAM controller model and a scoreboard of expected pixels.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_fb_reader;

    localparam int HAW  = 22;
    localparam int BASE = 32'h1000;
    localparam int FW   = 32;
    localparam int LAT  = 5;
`ifdef FB_READER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [HAW-1:0]  rd_addr;
    logic            rd_enable;
    logic            busy;
    logic            rd_ready;
    logic [15:0]     rd_data;
    logic            frame_start;
    logic            pix_req;
    logic [15:0]     pix_data;
    logic            pix_valid;
    logic            frame_done;
    logic            underflow;
    logic [15:0]     underflow_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    sdram_fb_reader #(
        .HADDR_WIDTH (HAW),
        .FB_BASE     (BASE),
        .FRAME_WORDS (FW),
        .FIFO_AW     (4)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .rd_addr       (rd_addr),
        .rd_enable     (rd_enable),
        .busy          (busy),
        .rd_ready      (rd_ready),
        .rd_data       (rd_data),
        .frame_start   (frame_start),
        .pix_req       (pix_req),
        .pix_data      (pix_data),
        .pix_valid     (pix_valid),
        .frame_done    (frame_done),
        .underflow     (underflow),
        .underflow_cnt (underflow_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] word_of(input logic [HAW-1:0] a);
        return {a[7:0], ~a[7:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Controller model: accepts a read when idle, raises busy, returns data
    // LAT cycles later with a one-cycle rd_ready. m_stall models refresh.
    // ------------------------------------------------------------------------
    logic [HAW-1:0] acc_q[$];
    logic [HAW-1:0] m_addr = '0;
    int             m_cnt = 0;
    int             m_stall = 0;

    initial begin
        busy     = 1'b0;
        rd_ready = 1'b0;
        rd_data  = 16'h0000;
        forever begin
            @(posedge clk); #1;
            rd_ready = 1'b0;
            if (rst) begin
                busy    = 1'b0;
                m_cnt   = 0;
                m_stall = 0;
            end else if (m_cnt != 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    busy     = 1'b0;
                    rd_ready = 1'b1;
                    rd_data  = word_of(m_addr);
                end
            end else if (m_stall != 0) begin
                m_stall--;
            end else if (rd_enable) begin
                busy   = 1'b1;
                m_addr = rd_addr;
                m_cnt  = LAT;
                acc_q.push_back(rd_addr);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Scoreboard: each successful pop is compared against the expected queue.
    // ------------------------------------------------------------------------
    logic [15:0] exp_q[$];

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && pix_req && pix_valid) begin
                if (exp_q.size() == 0) begin
                    chk("pop_unexpected", 32'd1, 32'd0);
                end else begin
                    chk("pop_data", {16'h0, pix_data}, {16'h0, exp_q.pop_front()});
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Vector table for the flag path (underflow, restart, done)
    // ------------------------------------------------------------------------
    typedef struct {
        logic        fs;
        logic        pr;
        logic        exp_valid;
        logic        exp_uf;
        logic [15:0] exp_cnt;
        logic        exp_fd;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int          base;
        int          hold;
        bit          ok;
        bit          seen32;
        logic [HAW-1:0] a0;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'd1, 1'b1};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'd2, 1'b1};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'd2, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'd3, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'd3, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd3, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd3, 1'b0};

        frame_start = 1'b0;
        pix_req     = 1'b0;
        rst         = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_addr",  32'(rd_addr), BASE);
        chk("rst_en",    32'(rd_enable), 32'd0);
        chk("rst_valid", 32'(pix_valid), 32'd0);
        chk("rst_data",  32'(pix_data), 32'd0);
        chk("rst_done",  32'(frame_done), 32'd1);
        chk("rst_uf",    32'(underflow), 32'd0);
        chk("rst_ufcnt", 32'(underflow_cnt), 32'd0);

        // Table: three pops on empty, then frame_start clears underflow
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            frame_start = vecs[i].fs;
            pix_req     = vecs[i].pr;
            if (vecs[i].fs) begin
                exp_q.delete();
                for (int k = 0; k < FW; k++) exp_q.push_back(word_of(HAW'(BASE + k)));
            end
            @(posedge clk); #1;
            chk($sformatf("vec%0d_valid", i), 32'(pix_valid), 32'(vecs[i].exp_valid));
            chk($sformatf("vec%0d_uf", i),    32'(underflow), 32'(vecs[i].exp_uf));
            chk($sformatf("vec%0d_ufcnt", i), 32'(underflow_cnt), STATS ? 32'(vecs[i].exp_cnt) : 32'd0);
            chk($sformatf("vec%0d_done", i),  32'(frame_done), 32'(vecs[i].exp_fd));
        end
        frame_start = 1'b0;
        pix_req     = 1'b0;

        // Fill with no pops: exactly 16 reads, FIFO full, no further request
        repeat (250) @(negedge clk);
        chk("fill_reads", acc_q.size(), 32'd16);
        for (int i = 0; i < 16 && i < acc_q.size(); i++)
            chk($sformatf("fill_addr%0d", i), 32'(acc_q[i]), BASE + i);
        chk("fill_head", 32'(pix_data), 32'(word_of(HAW'(BASE))));
        ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (rd_enable) ok = 1'b0;
        end
        chk("fill_no_req", 32'(ok), 32'd1);

        // Continuous pops: whole frame in order, done, no 33rd request
        @(posedge clk); #1;
        pix_req = 1'b1;
        seen32 = 1'b0;
        for (int c = 0; c < 1500 && !(exp_q.size() == 0 && frame_done); c++) begin
            @(negedge clk);
            if (!seen32 && acc_q.size() == FW) begin
                seen32 = 1'b1;
                chk("done_before_last_ret", 32'(frame_done), 32'd0);
            end
        end
        chk("frame_words_left", exp_q.size(), 32'd0);
        @(posedge clk); #1;
        pix_req = 1'b0;
        repeat (40) @(negedge clk);
        chk("frame_reads", acc_q.size(), FW);
        chk("frame_done", 32'(frame_done), 32'd1);
        chk("frame_idle_en", 32'(rd_enable), 32'd0);

        // Refresh stall during ISSUE: request held, one acceptance
        @(negedge clk);
        m_stall = 23;
        base = acc_q.size();
        @(posedge clk); #1; frame_start = 1'b1;
        @(posedge clk); #1; frame_start = 1'b0;
        for (int c = 0; c < 10 && !rd_enable; c++) @(negedge clk);
        a0 = rd_addr;
        hold = 0;
        ok = 1'b1;
        for (int c = 0; c < 60 && acc_q.size() == base; c++) begin
            @(negedge clk);
            if (acc_q.size() == base) begin
                if (!rd_enable || rd_addr !== a0) ok = 1'b0;
                hold++;
            end
        end
        chk("stall_hold_stable", 32'(ok), 32'd1);
        chk("stall_hold_long", 32'(hold >= 15), 32'd1);
        chk("stall_first_addr", (acc_q.size() > base) ? 32'(acc_q[base]) : 32'hDEAD, BASE);
        repeat (3) @(negedge clk);
        chk("stall_one_accept", acc_q.size(), base + 1);

        // frame_start while the read of BASE+7 is in WAIT
        @(posedge clk); #1; frame_start = 1'b1;
        @(posedge clk); #1; frame_start = 1'b0;
        base = acc_q.size();
        ok = 1'b0;
        for (int c = 0; c < 300 && !ok; c++) begin
            @(negedge clk);
            if (acc_q.size() > base && acc_q[$] == HAW'(BASE + 7)) ok = 1'b1;
        end
        chk("disc_reach_7", 32'(ok), 32'd1);
        @(posedge clk); #1;
        chk("disc_pre_valid", 32'(pix_valid), 32'd1);
        frame_start = 1'b1;
        @(posedge clk); #1; frame_start = 1'b0;
        base = acc_q.size();
        ok = 1'b1;
        for (int c = 0; c < 80 && acc_q.size() == base; c++) begin
            @(negedge clk);
            if (pix_valid) ok = 1'b0;
        end
        chk("disc_fifo_empty", 32'(ok), 32'd1);
        chk("disc_next_addr", (acc_q.size() > base) ? 32'(acc_q[base]) : 32'hDEAD, BASE);
        for (int c = 0; c < 20 && !pix_valid; c++) @(negedge clk);
        chk("disc_head", 32'(pix_data), 32'(word_of(HAW'(BASE))));

        // Asynchronous reset while a read is outstanding
        base = acc_q.size();
        for (int c = 0; c < 100 && acc_q.size() == base; c++) @(negedge clk);
        @(negedge clk);
        chk("arst_pre_valid", 32'(pix_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_addr",  32'(rd_addr), BASE);
        chk("arst_en",    32'(rd_enable), 32'd0);
        chk("arst_valid", 32'(pix_valid), 32'd0);
        chk("arst_data",  32'(pix_data), 32'd0);
        chk("arst_done",  32'(frame_done), 32'd1);
        chk("arst_uf",    32'(underflow), 32'd0);
        chk("arst_ufcnt", 32'(underflow_cnt), 32'd0);
        base = acc_q.size();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("arst_no_fetch", acc_q.size(), base);
        chk("arst_done_hold", 32'(frame_done), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
